pid_error_seq: RTL and testbench



---
 rtl/pid_error_seq_pkg.sv | 30 +++
 rtl/pid_error_seq_restador_saturado.sv | 25 ++
 rtl/pid_error_seq.sv | 126 ++++++++++++
 tb/tb_pid_error_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pid_error_seq_pkg.sv
// Shared constants for the PID error stage: datapath width, FSM encoding
// and the signed saturation limits of the error value.
`ifndef N
`define N 18
`endif

package pid_error_seq_pkg;

    localparam int N = `N;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REQ    = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_UPD    = 3'd4;
    localparam logic [2:0] ST_OUT    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_REQ    = ST_REQ,
        S_WAIT   = ST_WAIT,
        S_SETTLE = ST_SETTLE,
        S_UPD    = ST_UPD,
        S_OUT    = ST_OUT
    } state_t;

    localparam logic [N-1:0] EK_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] EK_MIN = {1'b1, {(N-1){1'b0}}};

endpackage

// File: rtl/pid_error_seq_restador_saturado.sv
// Combinational setpoint minus measurement, computed one bit wider and
// clipped back to the N-bit signed range.
module restador_saturado
    import pid_error_seq_pkg::*;
(
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y,
    output logic         sat
);

    logic [N:0] diff;

    always_comb begin
        diff = {a[N-1], a} - {b[N-1], b};
        y    = diff[N-1:0];
        sat  = 1'b0;
        // The wide result fits in N bits exactly when its top two bits agree.
        if (diff[N] != diff[N-1]) begin
            sat = 1'b1;
            y   = diff[N] ? EK_MIN : EK_MAX;
        end
    end

endmodule

// File: rtl/pid_error_seq.sv
// Per-period ADC sample request, saturated error computation and en1/en2
// strobe timing for the downstream integral block.
module pid_error_seq
    import pid_error_seq_pkg::*;
#(
    parameter int LAT     = 3,
    parameter int TIMEOUT = 255
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         sample_tick,
    input  logic [N-1:0] setpoint,
    input  logic [N-1:0] adc_data,
    input  logic         adc_valid,
    output logic         adc_start,
    output logic [N-1:0] ek,
    output logic         en1,
    output logic         en2,
    output logic         busy,
    output logic         sat,
    output logic         overrun,
    output logic         timeout
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = (LAT > 2) ? $clog2(LAT) : 1;

    state_t         state_reg, state_next;
    logic [TW-1:0]  wait_cnt_reg, wait_cnt_next;
    logic [SW-1:0]  settle_cnt_reg, settle_cnt_next;
    logic           load_ek;
    logic           timeout_next;

    logic [N-1:0]   diff_y;
    logic           diff_sat;

    logic [N-1:0]   ek_reg;
    logic           sat_reg, adc_start_reg, en1_reg, en2_reg;
    logic           busy_reg, overrun_reg, timeout_reg;

    restador_saturado u_sub (
        .a   (setpoint),
        .b   (adc_data),
        .y   (diff_y),
        .sat (diff_sat)
    );

    always_comb begin
        state_next      = state_reg;
        wait_cnt_next   = wait_cnt_reg;
        settle_cnt_next = settle_cnt_reg;
        load_ek         = 1'b0;
        timeout_next    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (sample_tick) state_next = S_REQ;
            end
            S_REQ: begin
                wait_cnt_next = '0;
                state_next    = S_WAIT;
            end
            S_WAIT: begin
                // A valid sample wins over an expiring wait on the same edge.
                if (adc_valid) begin
                    load_ek         = 1'b1;
                    settle_cnt_next = SW'(LAT - 1);
                    state_next      = S_SETTLE;
                end else if (wait_cnt_reg == TW'(TIMEOUT - 1)) begin
                    timeout_next = 1'b1;
                    state_next   = S_IDLE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            S_SETTLE: begin
                if (settle_cnt_reg == '0) state_next = S_UPD;
                else settle_cnt_next = settle_cnt_reg - 1'b1;
            end
            S_UPD:   state_next = S_OUT;
            S_OUT:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so each lines up with its state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            wait_cnt_reg   <= '0;
            settle_cnt_reg <= '0;
            ek_reg         <= '0;
            sat_reg        <= 1'b0;
            adc_start_reg  <= 1'b0;
            en1_reg        <= 1'b0;
            en2_reg        <= 1'b0;
            busy_reg       <= 1'b0;
            overrun_reg    <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wait_cnt_reg   <= wait_cnt_next;
            settle_cnt_reg <= settle_cnt_next;
            if (load_ek) begin
                ek_reg  <= diff_y;
                sat_reg <= diff_sat;
            end
            adc_start_reg  <= (state_next == S_REQ);
            en1_reg        <= (state_next == S_UPD);
            en2_reg        <= (state_next == S_OUT);
            busy_reg       <= (state_next != S_IDLE);
            overrun_reg    <= sample_tick && (state_reg != S_IDLE);
            timeout_reg    <= timeout_next;
        end
    end

    assign adc_start = adc_start_reg;
    assign ek        = ek_reg;
    assign sat       = sat_reg;
    assign en1       = en1_reg;
    assign en2       = en2_reg;
    assign busy      = busy_reg;
    assign overrun   = overrun_reg;
    assign timeout   = timeout_reg;

endmodule

// File: tb/tb_pid_error_seq.sv
// Directed bench for pid_error_seq: error arithmetic, strobe timing,
// timeout, overrun and asynchronous reset behaviour.
module tb_pid_error_seq;
    import pid_error_seq_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         sample_tick = 1'b0;
    logic [N-1:0] setpoint = '0;
    logic [N-1:0] adc_data = '0;
    logic         adc_valid = 1'b0;
    logic         adc_start, en1, en2, busy, sat, overrun, timeout;
    logic [N-1:0] ek;

    int checks = 0;
    int errors = 0;
    int en1_cnt = 0, en2_cnt = 0, start_cnt = 0, both_cnt = 0;
    int acc = 0, ik = 0;
    int e1_mark, s_mark, acc_mark;

    pid_error_seq dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .setpoint    (setpoint),
        .adc_data    (adc_data),
        .adc_valid   (adc_valid),
        .adc_start   (adc_start),
        .ek          (ek),
        .en1         (en1),
        .en2         (en2),
        .busy        (busy),
        .sat         (sat),
        .overrun     (overrun),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    // Strobe monitors plus a minimal integral-block stand-in (gain 7).
    always @(posedge clk) begin
        if (en1) en1_cnt <= en1_cnt + 1;
        if (en2) en2_cnt <= en2_cnt + 1;
        if (adc_start) start_cnt <= start_cnt + 1;
        if (en1 && en2) both_cnt <= both_cnt + 1;
        if (en1) acc <= acc + 7 * int'($signed(ek));
        if (en2) ik <= acc;
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after the ek-load edge V.
    task automatic start_sample(input int sp, input int ad, input int gap);
        setpoint    = sp[N-1:0];
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        chk("adc_start", adc_start, 1);
        step(1);
        chk("adc_start_drop", adc_start, 0);
        if (gap > 0) step(gap);
        adc_valid = 1'b1;
        adc_data  = ad[N-1:0];
        step(1);
        adc_valid = 1'b0;
        $display("sample sp=%0d y=%0d -> ek=%0d sat=%0d", sp, ad, $signed(ek), sat);
    endtask

    task automatic finish_strobes(input bit tick_at_out);
        chk("en1_at_V", en1, 0);
        step(2);
        chk("en1_at_V2", en1, 0);
        step(1);
        chk("en1_at_V3", en1, 1);
        chk("en2_at_V3", en2, 0);
        step(1);
        chk("en1_at_V4", en1, 0);
        chk("en2_at_V4", en2, 1);
        if (tick_at_out) sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        chk("en2_at_V5", en2, 0);
        chk("busy_at_V5", busy, 0);
        chk("overrun_at_out", overrun, tick_at_out);
        step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(3);
        chk("reset_ek", $signed(ek), 0);
        chk("reset_busy", busy, 0);
        chk("reset_en1", en1, 0);
        chk("reset_adc_start", adc_start, 0);
        reset = 1'b0;
        step(2);

        // Nominal sample
        start_sample(1000, 400, 1);
        chk("ek_600", $signed(ek), 600);
        chk("sat_600", sat, 0);
        finish_strobes(1'b0);

        // Positive and negative saturation
        start_sample(131071, -131072, 1);
        chk("ek_pos_clip", $signed(ek), 131071);
        chk("sat_pos_clip", sat, 1);
        finish_strobes(1'b0);
        start_sample(-131072, 131071, 1);
        chk("ek_neg_clip", $signed(ek), -131072);
        chk("sat_neg_clip", sat, 1);
        finish_strobes(1'b0);

        // Four periods of ek=10; tick during the last OUT is an overrun
        acc_mark = acc;
        e1_mark  = en1_cnt;
        for (int p = 0; p < 4; p++) begin
            start_sample(10, 0, 1);
            chk("ek_10", $signed(ek), 10);
            chk("sat_10", sat, 0);
            finish_strobes(p == 3);
        end
        chk("ik_delta_280", ik - acc_mark, 280);
        chk("en1_four", en1_cnt - e1_mark, 4);

        // ADC never answers
        e1_mark = en1_cnt;
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        step(1);
        step(254);
        chk("timeout_early", timeout, 0);
        chk("busy_waiting", busy, 1);
        step(1);
        chk("timeout_pulse", timeout, 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_ek_kept", $signed(ek), 10);
        step(1);
        chk("timeout_single", timeout, 0);
        chk("timeout_no_en1", en1_cnt - e1_mark, 0);
        $display("timeout sample: ek=%0d", $signed(ek));

        // adc_valid on the expiry edge is a valid sample
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        step(1);
        step(254);
        setpoint  = 18'd5;
        adc_data  = 18'd3;
        adc_valid = 1'b1;
        step(1);
        adc_valid = 1'b0;
        chk("expiry_no_timeout", timeout, 0);
        chk("expiry_ek", $signed(ek), 2);
        chk("expiry_busy", busy, 1);
        finish_strobes(1'b0);

        // Overrun during SETTLE
        s_mark = start_cnt;
        start_sample(20, 5, 1);
        chk("ek_15", $signed(ek), 15);
        step(1);
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        chk("overrun_pulse", overrun, 1);
        step(1);
        chk("overrun_single", overrun, 0);
        chk("overrun_en1", en1, 1);
        step(1);
        chk("overrun_en2", en2, 1);
        step(1);
        chk("overrun_idle", busy, 0);
        step(3);
        chk("overrun_one_start", start_cnt - s_mark, 1);

        // Asynchronous reset in SETTLE
        e1_mark = en1_cnt;
        start_sample(100, 50, 1);
        step(1);
        #2 reset = 1'b1;
        #1;
        chk("areset_ek", $signed(ek), 0);
        chk("areset_busy", busy, 0);
        chk("areset_sat", sat, 0);
        step(2);
        reset = 1'b0;
        step(10);
        chk("areset_no_en1", en1_cnt - e1_mark, 0);
        chk("areset_idle", busy, 0);
        $display("reset during settle: ek=%0d busy=%0d", $signed(ek), busy);

        chk("never_both", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
